// File: rtl/atm_session_ctrl.sv
// ATM session controller: drives the PIN checker, tracks sessions, runs balance ops.
// Define ATM_LOCKOUT_EN to build the failed-PIN lockout (tries counter, LOCKED state).
module atm_session_ctrl #(
`ifdef ATM_LOCKOUT_EN
    parameter int MAX_TRIES    = 3,
    parameter int LOCK_CYCLES  = 1000,
`endif
    parameter int NUM_USERS    = 10,
    parameter int BAL_W        = 16,
    parameter int INIT_BALANCE = 500,
    parameter int IDLE_TIMEOUT = 5000
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             CardIn,
    input  logic             EnterPin,
    output logic             Submit,
    input  logic             PassAuthorized,
    input  logic [3:0]       ID,
    input  logic             OpValid,
    input  logic [1:0]       Op,
    input  logic [BAL_W-1:0] Amount,
    output logic [BAL_W-1:0] Balance,
    output logic             OpDone,
    output logic             OpError,
    output logic             Authorized,
    output logic             Locked,
    output logic [2:0]       State
);
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_PIN_SUBMIT = 3'd1,
        S_PIN_CHECK  = 3'd2,
        S_MENU       = 3'd3,
        S_EXEC       = 3'd4,
        S_LOCKED     = 3'd5
    } state_t;

    localparam logic [1:0] OP_DEP = 2'b10;
    localparam logic [1:0] OP_WDR = 2'b11;
    localparam int IW = $clog2(IDLE_TIMEOUT);

    state_t           state;
    logic [BAL_W-1:0] bal [NUM_USERS];
    logic [3:0]       uid;
    logic [1:0]       op_q;
    logic [BAL_W-1:0] amt_q;
    logic [IW-1:0]    idle_cnt;
    logic [BAL_W-1:0] cur;
    logic [BAL_W:0]   sum;
    logic [BAL_W-1:0] diff;
    logic             id_ok;

`ifdef ATM_LOCKOUT_EN
    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam int LW = $clog2(LOCK_CYCLES + 1);
    logic [TW-1:0] tries;
    logic [LW-1:0] lock_cnt;
`else
    assign Locked = 1'b0;
`endif

    assign State = state;
    assign id_ok = PassAuthorized && (int'(ID) < NUM_USERS);

    always_comb begin
        cur  = bal[uid];
        sum  = {1'b0, cur} + {1'b0, amt_q};
        diff = cur - amt_q;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            Submit     <= 1'b0;
            Authorized <= 1'b0;
            OpDone     <= 1'b0;
            OpError    <= 1'b0;
            Balance    <= '0;
            uid        <= '0;
            op_q       <= '0;
            amt_q      <= '0;
            idle_cnt   <= '0;
            for (int i = 0; i < NUM_USERS; i++)
                bal[i] <= BAL_W'(INIT_BALANCE);
`ifdef ATM_LOCKOUT_EN
            Locked   <= 1'b0;
            tries    <= '0;
            lock_cnt <= '0;
`endif
        end else begin
            OpDone  <= 1'b0;
            OpError <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (CardIn && EnterPin) begin
                        state  <= S_PIN_SUBMIT;
                        Submit <= 1'b1;
                    end
                end
                S_PIN_SUBMIT: begin
                    if (!CardIn) begin
                        state  <= S_IDLE;
                        Submit <= 1'b0;
                    end else begin
                        state <= S_PIN_CHECK;
                    end
                end
                S_PIN_CHECK: begin
                    Submit <= 1'b0;
                    if (!CardIn) begin
                        state <= S_IDLE;
                    end else if (id_ok) begin
                        uid        <= ID;
                        idle_cnt   <= '0;
                        Authorized <= 1'b1;
                        state      <= S_MENU;
`ifdef ATM_LOCKOUT_EN
                        tries <= '0;
`endif
                    end else begin
`ifdef ATM_LOCKOUT_EN
                        tries <= tries + 1'b1;
                        if (tries == TW'(MAX_TRIES - 1)) begin
                            state    <= S_LOCKED;
                            Locked   <= 1'b1;
                            lock_cnt <= LW'(LOCK_CYCLES);
                        end else begin
                            state <= S_IDLE;
                        end
`else
                        state <= S_IDLE;
`endif
                    end
                end
                S_MENU: begin
                    if (!CardIn) begin
                        state      <= S_IDLE;
                        Authorized <= 1'b0;
                    end else if (OpValid) begin
                        idle_cnt <= '0;
                        if (Op != 2'b00) begin
                            op_q  <= Op;
                            amt_q <= Amount;
                            state <= S_EXEC;
                        end
                    end else if (idle_cnt == IW'(IDLE_TIMEOUT - 1)) begin
                        state      <= S_IDLE;
                        Authorized <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (!CardIn) begin
                        state      <= S_IDLE;
                        Authorized <= 1'b0;
                    end else begin
                        state    <= S_MENU;
                        idle_cnt <= '0;
                        case (op_q)
                            OP_DEP: begin
                                if (sum[BAL_W]) begin
                                    OpError <= 1'b1;
                                end else begin
                                    bal[uid] <= sum[BAL_W-1:0];
                                    Balance  <= sum[BAL_W-1:0];
                                    OpDone   <= 1'b1;
                                end
                            end
                            OP_WDR: begin
                                if (amt_q > cur) begin
                                    OpError <= 1'b1;
                                end else begin
                                    bal[uid] <= diff;
                                    Balance  <= diff;
                                    OpDone   <= 1'b1;
                                end
                            end
                            default: begin
                                Balance <= cur;
                                OpDone  <= 1'b1;
                            end
                        endcase
                    end
                end
`ifdef ATM_LOCKOUT_EN
                S_LOCKED: begin
                    if (lock_cnt <= LW'(1)) begin
                        state  <= S_IDLE;
                        Locked <= 1'b0;
                        tries  <= '0;
                    end else begin
                        lock_cnt <= lock_cnt - 1'b1;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_atm_session_ctrl.sv
// Self-checking bench for atm_session_ctrl: directed steps plus randomized ops
// checked against a per-user balance model and a consecutive-failure count.
module tb_atm_session_ctrl;
    logic        Clock = 1'b0;
    logic        Reset;
    logic        CardIn;
    logic        EnterPin;
    logic        Submit;
    logic        PassAuthorized;
    logic [3:0]  ID;
    logic        OpValid;
    logic [1:0]  Op;
    logic [15:0] Amount;
    logic [15:0] Balance;
    logic        OpDone;
    logic        OpError;
    logic        Authorized;
    logic        Locked;
    logic [2:0]  State;

    int vectors = 0;
    int miscompares = 0;
    int bal_m [10];
    int exp_bal;
    int sess_id;
    int tries_m;

    atm_session_ctrl dut (
        .Clock(Clock), .Reset(Reset), .CardIn(CardIn), .EnterPin(EnterPin),
        .Submit(Submit), .PassAuthorized(PassAuthorized), .ID(ID),
        .OpValid(OpValid), .Op(Op), .Amount(Amount), .Balance(Balance),
        .OpDone(OpDone), .OpError(OpError), .Authorized(Authorized),
        .Locked(Locked), .State(State)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 10; i++) bal_m[i] = 500;
        exp_bal = 0;
        tries_m = 0;
    endtask

    // one PIN attempt; expected outcome from the failure-count rule
    task automatic attempt(input int id, input bit pass);
        int exp_state;
        if (pass && id < 10) begin
            exp_state = 3;
            tries_m = 0;
        end else begin
            tries_m++;
`ifdef ATM_LOCKOUT_EN
            exp_state = (tries_m == 3) ? 5 : 0;
`else
            exp_state = 0;
`endif
        end
        CardIn = 1; EnterPin = 1;
        tick();
        check("pin_submit_state", State, 1);
        check("submit_cycle1", Submit, 1);
        check("auth_early1", Authorized, 0);
        EnterPin = 0; PassAuthorized = pass; ID = 4'(id);
        tick();
        check("pin_check_state", State, 2);
        check("submit_cycle2", Submit, 1);
        check("auth_early2", Authorized, 0);
        tick();
        PassAuthorized = 0; ID = 0;
        check("login_state", State, exp_state);
        check("login_auth", Authorized, exp_state == 3);
        check("submit_off", Submit, 0);
        check("login_locked", Locked, exp_state == 5);
        if (exp_state == 3) sess_id = id;
    endtask

    task automatic do_op(input int op, input int amt);
        int cur;
        int nb;
        bit err;
        cur = bal_m[sess_id];
        nb = cur;
        err = 0;
        if (op == 2) begin
            if (cur + amt > 65535) err = 1; else nb = cur + amt;
        end else if (op == 3) begin
            if (amt > cur) err = 1; else nb = cur - amt;
        end
        OpValid = 1; Op = 2'(op); Amount = 16'(amt);
        tick();
        OpValid = 0; Op = 0;
        check("exec_state", State, 4);
        check("exec_no_done", OpDone, 0);
        tick();
        check("op_done", OpDone, !err);
        check("op_error", OpError, err);
        if (!err) begin
            bal_m[sess_id] = nb;
            exp_bal = nb;
        end
        check("op_balance", Balance, exp_bal);
        check("back_to_menu", State, 3);
    endtask

    task automatic logout();
        CardIn = 0;
        tick();
        check("logout_state", State, 0);
        check("logout_auth", Authorized, 0);
        check("logout_balance", Balance, exp_bal);
    endtask

    initial begin
        int op;
        int amt;
        bit held;
        Reset = 1; CardIn = 0; EnterPin = 0; PassAuthorized = 0; ID = 0;
        OpValid = 0; Op = 0; Amount = 0;
        model_reset();
        tick();
        check("rst_state", State, 0);
        check("rst_submit", Submit, 0);
        check("rst_auth", Authorized, 0);
        check("rst_locked", Locked, 0);
        check("rst_done", OpDone, 0);
        check("rst_error", OpError, 0);
        check("rst_balance", Balance, 0);
        Reset = 0;
        tick();

        attempt(2, 1);
        do_op(3, 200);
        check("wdr200_balance", Balance, 300);
        do_op(3, 301);
        check("wdr301_balance", Balance, 300);
        do_op(2, 65535 - 300 + 1);
        do_op(2, 100);
        check("dep100_balance", Balance, 400);
        do_op(3, 400);
        do_op(1, 0);
        do_op(2, 400);
        logout();

        for (int s = 0; s < 4; s++) begin
            attempt($urandom_range(0, 9), 1);
            for (int k = 0; k < 8; k++) begin
                op = $urandom_range(1, 3);
                case ($urandom_range(0, 3))
                    0: amt = $urandom_range(0, 300);
                    1: amt = $urandom_range(0, 65535);
                    2: amt = bal_m[sess_id];
                    default: amt = 65535 - bal_m[sess_id] + $urandom_range(0, 1);
                endcase
                if (amt > 65535) amt = 65535;
                do_op(op, amt);
            end
            logout();
        end

        attempt(3, 0);
        CardIn = 0;
        tick();
        check("fail_card_out", State, 0);
        attempt(12, 1);
        attempt(1, 0);
`ifdef ATM_LOCKOUT_EN
        held = 1;
        for (int c = 0; c < 999; c++) begin
            EnterPin = 1'($urandom_range(0, 1));
            PassAuthorized = 1; CardIn = 1'($urandom_range(0, 1));
            tick();
            if (Locked !== 1'b1 || State !== 3'd5) held = 0;
        end
        check("lock_held", held, 1);
        EnterPin = 0; PassAuthorized = 0; CardIn = 1;
        tick();
        check("unlock_state", State, 0);
        check("unlock_locked", Locked, 0);
        tries_m = 0;
`else
        repeat (5) tick();
        check("nolock_state", State, 0);
        check("nolock_locked", Locked, 0);
`endif
        attempt(4, 0);

        attempt(5, 1);
        repeat (3000) tick();
        check("tmo_partial", Authorized, 1);
        OpValid = 1; Op = 0;
        tick();
        OpValid = 0;
        check("op00_ignored", State, 3);
        repeat (4999) tick();
        check("tmo_not_yet", State, 3);
        tick();
        check("tmo_state", State, 0);
        check("tmo_auth", Authorized, 0);
        check("tmo_balance", Balance, exp_bal);

        attempt(2, 1);
        OpValid = 1; Op = 3; Amount = 50; CardIn = 0;
        tick();
        OpValid = 0; Op = 0;
        check("drop_op_state", State, 0);
        check("drop_op_done", OpDone, 0);
        check("drop_op_err", OpError, 0);
        tick();
        check("drop_op_done2", OpDone | OpError, 0);
        attempt(2, 1);
        OpValid = 1; Op = 2; Amount = 77;
        tick();
        OpValid = 0; Op = 0;
        check("drop_exec_state4", State, 4);
        CardIn = 0;
        tick();
        check("drop_exec_state", State, 0);
        check("drop_exec_done", OpDone | OpError, 0);
        attempt(2, 1);
        do_op(1, 0);

        OpValid = 1; Op = 3; Amount = 100;
        tick();
        OpValid = 0; Op = 0;
        check("rst_exec_state4", State, 4);
        Reset = 1;
        #1;
        model_reset();
        check("arst_state", State, 0);
        check("arst_balance", Balance, 0);
        check("arst_auth", Authorized, 0);
        check("arst_done", OpDone | OpError, 0);
        tick();
        check("arst_done_after", OpDone | OpError, 0);
        Reset = 0;
        tick();
        attempt(2, 1);
        do_op(1, 0);
        check("post_rst_bal2", Balance, 500);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
